// File: rtl/robo_ambiente_if.sv
// Command/sensor bundle between the robot controller (master) and the grid-world model (slave).
interface robo_ambiente_if #(
    parameter int COORD_W  = 3,
    parameter int PASSOS_W = 16
);
    logic                avancar;
    logic                girar;
    logic                recolher_entulho;
    logic                head;
    logic                left;
    logic                under;
    logic                rubble;
    logic [COORD_W-1:0]  pos_x;
    logic [COORD_W-1:0]  pos_y;
    logic [1:0]          direcao;
    logic                colisao;
    logic                erro_comando;
    logic [PASSOS_W-1:0] passos;

    modport master (
        output avancar, girar, recolher_entulho,
        input  head, left, under, rubble, pos_x, pos_y, direcao,
        input  colisao, erro_comando, passos
    );

    modport slave (
        input  avancar, girar, recolher_entulho,
        output head, left, under, rubble, pos_x, pos_y, direcao,
        output colisao, erro_comando, passos
    );
endinterface

// File: rtl/robo_ambiente.sv
// Grid-world environment: tracks robot pose and a mutable rubble map, and
// derives the controller's sensors from the registered pose/map.
module robo_ambiente #(
    parameter int                         LARGURA      = 8,
    parameter int                         ALTURA       = 8,
    parameter int                         COORD_W      = 3,
    parameter int                         X0           = 0,
    parameter int                         Y0           = 0,
    parameter int                         DIR0         = 0,
    parameter int                         SAIDA_X      = 7,
    parameter int                         SAIDA_Y      = 7,
    parameter logic [LARGURA*ALTURA-1:0]  MAPA_PAREDE  = '0,
    parameter logic [LARGURA*ALTURA-1:0]  MAPA_ENTULHO = '0,
    parameter int                         CICLOS_REC   = 3,
    parameter int                         PASSOS_W     = 16
) (
    input  logic            clock,
    input  logic            reset,
    robo_ambiente_if.slave  bus
);
    localparam int CELULAS = LARGURA * ALTURA;
    localparam int IDX_W   = (CELULAS > 1) ? $clog2(CELULAS) : 1;
    localparam int CNT_W   = $clog2(CICLOS_REC + 1);
    localparam logic [COORD_W-1:0] UM = COORD_W'(1);

    typedef struct packed {
        logic               fora;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } celula_t;

    logic [COORD_W-1:0]  x_reg;
    logic [COORD_W-1:0]  y_reg;
    logic [1:0]          dir_reg;
    logic [CELULAS-1:0]  entulho_reg;
    logic [CNT_W-1:0]    cont_reg;
    logic [PASSOS_W-1:0] passos_reg;
    logic                colisao_reg;
    logic                erro_reg;

    celula_t             frente;
    logic [IDX_W-1:0]    idx_frente;
    logic                parede_frente;
    logic                parede_esquerda;
    logic                entulho_frente;
    logic [2:0]          cmd;

    function automatic logic [IDX_W-1:0] indice(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
        return IDX_W'(y) * IDX_W'(LARGURA) + IDX_W'(x);
    endfunction

    // Neighbour in heading d; stepping off any edge (including below 0) marks it fora.
    function automatic celula_t vizinha(input logic [1:0]         d,
                                        input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y);
        celula_t c;
        c.fora = 1'b0;
        c.x    = x;
        c.y    = y;
        case (d)
            2'd0: begin
                c.fora = (y == COORD_W'(ALTURA - 1));
                c.y    = y + UM;
            end
            2'd1: begin
                c.fora = (x == COORD_W'(LARGURA - 1));
                c.x    = x + UM;
            end
            2'd2: begin
                c.fora = (y == '0);
                c.y    = y - UM;
            end
            default: begin
                c.fora = (x == '0);
                c.x    = x - UM;
            end
        endcase
        return c;
    endfunction

    function automatic logic parede(input celula_t c);
        return c.fora | MAPA_PAREDE[indice(c.x, c.y)];
    endfunction

    always_comb begin
        frente          = vizinha(dir_reg, x_reg, y_reg);
        idx_frente      = indice(frente.x, frente.y);
        parede_frente   = parede(frente);
        parede_esquerda = parede(vizinha(dir_reg + 2'd3, x_reg, y_reg));
        entulho_frente  = !frente.fora && entulho_reg[idx_frente];
    end

    assign cmd = {bus.avancar, bus.girar, bus.recolher_entulho};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_reg       <= COORD_W'(X0);
            y_reg       <= COORD_W'(Y0);
            dir_reg     <= 2'(DIR0);
            entulho_reg <= MAPA_ENTULHO;
            cont_reg    <= '0;
            passos_reg  <= '0;
            colisao_reg <= 1'b0;
            erro_reg    <= 1'b0;
        end else begin
            // Pulses and the collection counter default to cleared; only an
            // uninterrupted run of valid recolher cycles keeps counting.
            colisao_reg <= 1'b0;
            erro_reg    <= 1'b0;
            cont_reg    <= '0;
            case (cmd)
                3'b000: ;
                3'b100: begin
                    if (parede_frente || entulho_frente) begin
                        colisao_reg <= 1'b1;
                    end else begin
                        x_reg <= frente.x;
                        y_reg <= frente.y;
                        if (passos_reg != '1) begin
                            passos_reg <= passos_reg + PASSOS_W'(1);
                        end
                    end
                end
                3'b010: dir_reg <= dir_reg + 2'd1;
                3'b001: begin
                    if (entulho_frente) begin
                        if (cont_reg == CNT_W'(CICLOS_REC - 1)) begin
                            entulho_reg[idx_frente] <= 1'b0;
                        end else begin
                            cont_reg <= cont_reg + CNT_W'(1);
                        end
                    end
                end
                default: erro_reg <= 1'b1;
            endcase
        end
    end

    assign bus.head         = parede_frente;
    assign bus.left         = parede_esquerda;
    assign bus.rubble       = entulho_frente;
    assign bus.under        = (x_reg == COORD_W'(SAIDA_X)) && (y_reg == COORD_W'(SAIDA_Y));
    assign bus.pos_x        = x_reg;
    assign bus.pos_y        = y_reg;
    assign bus.direcao      = dir_reg;
    assign bus.colisao      = colisao_reg;
    assign bus.erro_comando = erro_reg;
    assign bus.passos       = passos_reg;
endmodule

// File: tb/tb_robo_ambiente.sv
// Directed scenarios followed by random command traffic, checked against a
// cell-level grid model (coordinates as integers, map as a bit per cell).
module tb_robo_ambiente;
    localparam int W = 8;
    localparam int H = 8;
    localparam logic [63:0] PAREDE_A = (64'd1 << (0*8+1)) | (64'd1 << (3*8+2)) |
                                       (64'd1 << (5*8+5)) | (64'd1 << (6*8+3)) |
                                       (64'd1 << (1*8+6));
    localparam logic [63:0] ENTULHO_A = (64'd1 << (1*8+0)) | (64'd1 << (4*8+4)) |
                                        (64'd1 << (3*8+2)) | (64'd1 << (6*8+6)) |
                                        (64'd1 << (5*8+1));

    logic clock;
    logic reset;

    robo_ambiente_if #(.COORD_W(3), .PASSOS_W(16)) ia ();
    robo_ambiente_if #(.COORD_W(3), .PASSOS_W(16)) ib ();

    robo_ambiente #(
        .LARGURA(W), .ALTURA(H), .COORD_W(3), .X0(0), .Y0(0), .DIR0(0),
        .SAIDA_X(0), .SAIDA_Y(1), .MAPA_PAREDE(PAREDE_A), .MAPA_ENTULHO(ENTULHO_A),
        .CICLOS_REC(3), .PASSOS_W(16)
    ) dut_a (.clock(clock), .reset(reset), .bus(ia));

    robo_ambiente #(
        .LARGURA(W), .ALTURA(H), .COORD_W(3), .X0(0), .Y0(0), .DIR0(3),
        .SAIDA_X(7), .SAIDA_Y(7), .MAPA_PAREDE(64'd0), .MAPA_ENTULHO(64'd0),
        .CICLOS_REC(3), .PASSOS_W(16)
    ) dut_b (.clock(clock), .reset(reset), .bus(ib));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          mx, my, md, mcnt, mpassos;
    bit          mcol, merr;
    bit [63:0]   mrub;
    bit [63:0]   wall_map;

    function automatic int ddx(int d);
        return (d == 1) ? 1 : (d == 3) ? -1 : 0;
    endfunction
    function automatic int ddy(int d);
        return (d == 0) ? 1 : (d == 2) ? -1 : 0;
    endfunction
    function automatic bit fora(int x, int y);
        return (x < 0) || (x >= W) || (y < 0) || (y >= H);
    endfunction
    function automatic bit parede_em(int x, int y);
        if (fora(x, y)) return 1'b1;
        return wall_map[y*W + x];
    endfunction
    function automatic bit entulho_em(int x, int y);
        if (fora(x, y)) return 1'b0;
        return mrub[y*W + x];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; md = 0; mcnt = 0; mpassos = 0;
        mcol = 1'b0; merr = 1'b0;
        mrub = ENTULHO_A;
    endtask

    task automatic model_step(bit a, bit g, bit r);
        int n;
        int fx;
        int fy;
        n  = int'(a) + int'(g) + int'(r);
        fx = mx + ddx(md);
        fy = my + ddy(md);
        mcol = 1'b0;
        merr = 1'b0;
        if (n > 1) begin
            merr = 1'b1;
            mcnt = 0;
        end else if (a) begin
            mcnt = 0;
            if (parede_em(fx, fy) || entulho_em(fx, fy)) mcol = 1'b1;
            else begin
                mx = fx; my = fy;
                if (mpassos < 65535) mpassos++;
            end
        end else if (g) begin
            md   = (md + 1) % 4;
            mcnt = 0;
        end else if (r && entulho_em(fx, fy)) begin
            mcnt++;
            if (mcnt == 3) begin
                mrub[fy*W + fx] = 1'b0;
                mcnt = 0;
            end
        end else begin
            mcnt = 0;
        end
    endtask

    task automatic check_all();
        int fx, fy, ld, lx, ly;
        fx = mx + ddx(md);
        fy = my + ddy(md);
        ld = (md + 3) % 4;
        lx = mx + ddx(ld);
        ly = my + ddy(ld);
        chk("head",    32'(ia.head),         32'(parede_em(fx, fy)));
        chk("left",    32'(ia.left),         32'(parede_em(lx, ly)));
        chk("rubble",  32'(ia.rubble),       32'(entulho_em(fx, fy)));
        chk("under",   32'(ia.under),        32'((mx == 0) && (my == 1)));
        chk("pos_x",   32'(ia.pos_x),        32'(mx));
        chk("pos_y",   32'(ia.pos_y),        32'(my));
        chk("direcao", 32'(ia.direcao),      32'(md));
        chk("colisao", 32'(ia.colisao),      32'(mcol));
        chk("erro",    32'(ia.erro_comando), 32'(merr));
        chk("passos",  32'(ia.passos),       32'(mpassos));
    endtask

    task automatic step(bit a, bit g, bit r, bit bav = 1'b0);
        @(negedge clock);
        ia.avancar          = a;
        ia.girar            = g;
        ia.recolher_entulho = r;
        ib.avancar          = bav;
        @(posedge clock);
        model_step(a, g, r);
        #1;
        check_all();
        $display("step a=%0b g=%0b r=%0b -> pos=(%0d,%0d) dir=%0d rubble=%0b col=%0b err=%0b passos=%0d",
                 a, g, r, ia.pos_x, ia.pos_y, ia.direcao, ia.rubble, ia.colisao,
                 ia.erro_comando, ia.passos);
    endtask

    task automatic do_reset();
        @(negedge clock);
        ia.avancar = 1'b0; ia.girar = 1'b0; ia.recolher_entulho = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        $display("reset -> pos=(%0d,%0d) dir=%0d rubble=%0b", ia.pos_x, ia.pos_y, ia.direcao, ia.rubble);
        #1 reset = 1'b0;
    endtask

    initial begin
        wall_map = PAREDE_A;
        reset = 1'b1;
        ia.avancar = 1'b0; ia.girar = 1'b0; ia.recolher_entulho = 1'b0;
        ib.avancar = 1'b0; ib.girar = 1'b0; ib.recolher_entulho = 1'b0;
        model_reset();
        #12;
        // Reset pose at (0,0) facing N: rubble directly ahead, west edge on the left
        check_all();
        chk("rst_head",   32'(ia.head),   32'd0);
        chk("rst_left",   32'(ia.left),   32'd1);
        chk("rst_under",  32'(ia.under),  32'd0);
        chk("rst_rubble", 32'(ia.rubble), 32'd1);
        chk("b_rst_dir",  32'(ib.direcao), 32'd3);
        chk("b_rst_head", 32'(ib.head),   32'd1);
        $display("reset released");
        @(negedge clock);
        reset = 1'b0;

        // Heading W at (0,0) on the second instance: avancar refused
        step(0, 0, 0, 1);
        chk("b_colisao", 32'(ib.colisao), 32'd1);
        chk("b_pos_x",   32'(ib.pos_x),   32'd0);
        chk("b_passos",  32'(ib.passos),  32'd0);
        ib.avancar = 1'b0;

        step(1, 0, 0);                       // blocked by rubble
        chk("rubble_colisao", 32'(ia.colisao), 32'd1);
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 0); step(0, 0, 1); step(0, 0, 1);
        chk("gap_rubble", 32'(ia.rubble), 32'd1);
        do_reset();                          // discard partial count of 2
        step(0, 0, 1); step(0, 0, 1);
        chk("post_rst_rubble", 32'(ia.rubble), 32'd1);
        step(0, 0, 1);
        chk("cleared_rubble", 32'(ia.rubble), 32'd0);
        do_reset();
        chk("restored_rubble", 32'(ia.rubble), 32'd1);
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
        step(1, 0, 0);
        chk("move_pos_y",  32'(ia.pos_y),  32'd1);
        chk("move_under",  32'(ia.under),  32'd1);
        chk("move_passos", 32'(ia.passos), 32'd1);
        step(1, 1, 0);
        chk("double_erro", 32'(ia.erro_comando), 32'd1);
        step(0, 0, 0);
        chk("erro_pulse",  32'(ia.erro_comando), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0);
            chk("girar_dir", 32'(ia.direcao), 32'(i % 4));
        end

        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = int'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) do_reset();
            else if (sel <= 4)  step(1, 0, 0);
            else if (sel <= 7)  step(0, 1, 0);
            else if (sel <= 12) step(0, 0, 1);
            else if (sel == 13) step(0, 0, 0);
            else if (sel == 14) begin
                case ($urandom_range(0, 2))
                    0:       step(1, 1, 0);
                    1:       step(1, 0, 1);
                    default: step(0, 1, 1);
                endcase
            end else step(1, 1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
